// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares the single-port 64x10 block RAM between CPU port C and debug/loader port D.
// Latency: grant is combinational (0 cycles); read data returns 1 cycle after the granting edge.
// Backpressure: a losing requester is simply not granted and must hold its request; each denied cycle counts in o_conflicts.
//
// Ports:
//   i_clk, i_rst                  clock (rising edge), asynchronous active-low reset
//   i_c_* / i_d_*                 per-port request: req, we (1 = write), addr, wdata
//   i_d_lock                      while D holds the grant with this high, C is never granted
//   o_c_gnt / o_d_gnt             request accepted this cycle (combinational)
//   o_c_rvalid/rdata, o_d_*       registered read return, rdata forced to 0 when not valid
//   o_ram_we/addr/wdata           RAM control pins, driven by the winner (all 0 when idle)
//   i_ram_rdata                   RAM registered read output
//   o_conflicts                   saturating count of cycles in which a request was denied
module fb_mem_arbiter #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst,

    input  logic                     i_c_req,
    input  logic                     i_c_we,
    input  logic [ADDRESS_WIDTH-1:0] i_c_addr,
    input  logic [DATA_WIDTH-1:0]    i_c_wdata,

    input  logic                     i_d_req,
    input  logic                     i_d_we,
    input  logic [ADDRESS_WIDTH-1:0] i_d_addr,
    input  logic [DATA_WIDTH-1:0]    i_d_wdata,
    input  logic                     i_d_lock,

    output logic                     o_c_gnt,
    output logic                     o_d_gnt,
    output logic                     o_c_rvalid,
    output logic [DATA_WIDTH-1:0]    o_c_rdata,
    output logic                     o_d_rvalid,
    output logic [DATA_WIDTH-1:0]    o_d_rdata,

    output logic                     o_ram_we,
    output logic [ADDRESS_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0]    o_ram_wdata,
    input  logic [DATA_WIDTH-1:0]    i_ram_rdata,

    output logic [7:0]               o_conflicts
);

    // One RAM access as seen on the RAM pins.
    typedef struct packed {
        logic                     we;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    wdata;
    } acc_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    // State
    logic       r_last;        // port of the most recent grant
    logic       r_lock_held;   // D won while asserting d_lock and has not dropped it since
    logic       r_pend_c;      // C read granted at the previous edge
    logic       r_pend_d;      // D read granted at the previous edge
    logic [7:0] r_conflicts;

    // Combinational
    logic w_lock;
    logic w_c_gnt;
    logic w_d_gnt;
    logic w_denied;
    acc_t w_c_acc;
    acc_t w_d_acc;
    acc_t w_win_acc;

    assign w_c_acc = '{we: i_c_we, addr: i_c_addr, wdata: i_c_wdata};
    assign w_d_acc = '{we: i_d_we, addr: i_d_addr, wdata: i_d_wdata};

    // The lock only blocks C while d_lock is still high: in the cycle d_lock
    // falls the register is still set, but the contest already reverts to
    // round-robin (last = D there, so a waiting C wins immediately).
    assign w_lock = r_lock_held & i_d_lock;

    // Winner selection. Nothing is granted while reset is asserted.
    always_comb begin
        w_c_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (i_rst) begin
            case ({i_c_req, i_d_req})
                2'b10: w_c_gnt = ~w_lock;
                2'b01: w_d_gnt = 1'b1;
                2'b11: begin
                    if (w_lock || (r_last == PORT_C)) begin
                        w_d_gnt = 1'b1;
                    end else begin
                        w_c_gnt = 1'b1;
                    end
                end
                default: begin
                    w_c_gnt = 1'b0;
                    w_d_gnt = 1'b0;
                end
            endcase
        end
    end

    // RAM pins follow the winner; idle cycles drive all zeros.
    always_comb begin
        w_win_acc = '0;
        if (w_c_gnt) begin
            w_win_acc = w_c_acc;
        end else if (w_d_gnt) begin
            w_win_acc = w_d_acc;
        end
    end

    assign w_denied = (i_c_req & ~w_c_gnt) | (i_d_req & ~w_d_gnt);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_last      <= PORT_D;   // C wins the first contest after reset
            r_lock_held <= 1'b0;
            r_pend_c    <= 1'b0;
            r_pend_d    <= 1'b0;
            r_conflicts <= 8'd0;
        end else begin
            if (w_c_gnt) begin
                r_last <= PORT_C;
            end else if (w_d_gnt) begin
                r_last <= PORT_D;
            end

            if (!i_d_lock) begin
                r_lock_held <= 1'b0;
            end else if (w_d_gnt) begin
                r_lock_held <= 1'b1;
            end

            // At most one grant per cycle, so these are mutually exclusive.
            r_pend_c <= w_c_gnt & ~i_c_we;
            r_pend_d <= w_d_gnt & ~i_d_we;

            if (w_denied && (r_conflicts != 8'hFF)) begin
                r_conflicts <= r_conflicts + 8'd1;
            end
        end
    end

    assign o_c_gnt     = w_c_gnt;
    assign o_d_gnt     = w_d_gnt;
    assign o_ram_we    = w_win_acc.we;
    assign o_ram_addr  = w_win_acc.addr;
    assign o_ram_wdata = w_win_acc.wdata;

    // RAM output is only meaningful to the port whose read it answers.
    assign o_c_rvalid  = r_pend_c;
    assign o_d_rvalid  = r_pend_d;
    assign o_c_rdata   = r_pend_c ? i_ram_rdata : '0;
    assign o_d_rdata   = r_pend_d ? i_ram_rdata : '0;
    assign o_conflicts = r_conflicts;

    a_one_grant: assert property (@(posedge i_clk) disable iff (!i_rst) !(w_c_gnt && w_d_gnt));
    a_one_pend:  assert property (@(posedge i_clk) disable iff (!i_rst) !(r_pend_c && r_pend_d));

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: directed scenarios with literal expectations,
// then constrained-random traffic, all checked each cycle against a
// behavioural model of the arbitration rules and the RAM contents.
module tb_fb_mem_arbiter;
    localparam int AW = 6;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic          d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
    logic [AW-1:0] c_addr = '0, d_addr = '0;
    logic [DW-1:0] c_wdata = '0, d_wdata = '0;

    logic          c_gnt, d_gnt, c_rvalid, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [7:0]    conflicts;

    int errors = 0;
    int checks = 0;

    fb_mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_lock(d_lock),
        .o_c_gnt(c_gnt), .o_d_gnt(d_gnt),
        .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
        .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
        .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata),
        .o_conflicts(conflicts)
    );

    always #5 clk = ~clk;

    // Block RAM next to the arbiter: write at the edge, registered read.
    logic [DW-1:0] ram [64];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_last = 1'b1;     // 0 = C granted last, 1 = D
    logic          m_lock = 1'b0;
    logic          m_pend_c = 1'b0, m_pend_d = 1'b0;
    logic [DW-1:0] m_exp_c = '0, m_exp_d = '0;
    int            m_conf = 0;
    logic [DW-1:0] m_mem [64];
    logic [1:0]    m_w;               // {D wins, C wins} used at the edge
    logic [1:0]    e_w;               // same, evaluated mid-cycle for checking
    logic          seen_c_gnt = 1'b0, seen_d_gnt = 1'b0;

    // Returns {d_gnt, c_gnt} from the current requests and model state.
    function automatic logic [1:0] winner();
        logic locked;
        locked = m_lock && d_lock;
        if (!rst) return 2'b00;
        if (c_req && d_req) return (locked || !m_last) ? 2'b10 : 2'b01;
        if (c_req) return locked ? 2'b00 : 2'b01;
        if (d_req) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_last = 1'b1; m_lock = 1'b0;
            m_pend_c = 1'b0; m_pend_d = 1'b0; m_conf = 0;
        end else begin
            m_w = winner();
            m_pend_c = m_w[0] && !c_we;
            m_pend_d = m_w[1] && !d_we;
            if (m_pend_c) m_exp_c = m_mem[c_addr];
            if (m_pend_d) m_exp_d = m_mem[d_addr];
            if (m_w[0] && c_we) m_mem[c_addr] = c_wdata;
            if (m_w[1] && d_we) m_mem[d_addr] = d_wdata;
            if ((c_req && !m_w[0]) || (d_req && !m_w[1]))
                m_conf = (m_conf < 255) ? m_conf + 1 : 255;
            if (!d_lock) m_lock = 1'b0;
            else if (m_w[1]) m_lock = 1'b1;
            if (m_w[0]) m_last = 1'b0;
            else if (m_w[1]) m_last = 1'b1;
        end
    end

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clk) begin
        e_w = winner();
        check("c_gnt", 32'(c_gnt), 32'(e_w[0]));
        check("d_gnt", 32'(d_gnt), 32'(e_w[1]));
        check("ram_we", 32'(ram_we), 32'(e_w[0] ? c_we : e_w[1] ? d_we : 1'b0));
        check("ram_addr", 32'(ram_addr), 32'(e_w[0] ? c_addr : e_w[1] ? d_addr : '0));
        check("ram_wdata", 32'(ram_wdata), 32'(e_w[0] ? c_wdata : e_w[1] ? d_wdata : '0));
        check("c_rvalid", 32'(c_rvalid), 32'(m_pend_c));
        check("d_rvalid", 32'(d_rvalid), 32'(m_pend_d));
        check("c_rdata", 32'(c_rdata), 32'(m_pend_c ? m_exp_c : '0));
        check("d_rdata", 32'(d_rdata), 32'(m_pend_d ? m_exp_d : '0));
        check("conflicts", 32'(conflicts), 32'(m_conf));
        seen_c_gnt = e_w[0];
        seen_d_gnt = e_w[1];
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < 64; i++) begin
            v = DW'($urandom);
            ram[i] <= v;
            m_mem[i] = v;
        end

        // Reset with both ports requesting: nothing granted, then C first.
        c_req = 1'b1; c_addr = 6'd0; d_req = 1'b1; d_addr = 6'd1;
        @(negedge clk);
        check("rst_c_gnt", 32'(c_gnt), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_conflicts", 32'(conflicts), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("first_gnt_c", 32'(c_gnt), 32'd1);
        check("first_gnt_d", 32'(d_gnt), 32'd0);
        tick();

        // D writes 0x155 to 50 and reads it back.
        c_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd50; d_wdata = 10'h155;
        @(negedge clk);
        check("wr_d_gnt", 32'(d_gnt), 32'd1);
        tick();
        d_we = 1'b0;
        @(negedge clk);
        check("rd_d_gnt", 32'(d_gnt), 32'd1);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        check("rd_d_rvalid", 32'(d_rvalid), 32'd1);
        check("rd_d_rdata", 32'(d_rdata), 32'h155);
        check("rd_c_rvalid", 32'(c_rvalid), 32'd0);
        tick();

        // Preload 51/52, then six cycles of contention.
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd51; d_wdata = 10'h2AA;
        tick();
        d_addr = 6'd52; d_wdata = 10'h0F0;
        tick();
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 6'd51;
        d_req = 1'b1; d_we = 1'b0; d_addr = 6'd52;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_c_gnt", 32'(c_gnt), 32'((k % 2) == 0));
            check("rr_d_gnt", 32'(d_gnt), 32'((k % 2) == 1));
            if (k == 1) check("rr_c_rdata", 32'(c_rdata), 32'h2AA);
            if (k == 2) check("rr_d_rdata", 32'(d_rdata), 32'h0F0);
            tick();
        end
        c_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("rr_conflicts", 32'(conflicts), 32'd6);
        tick();

        // Lock: C wins once so D takes the next contest, then holds it.
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 6'd10;
        @(negedge clk);
        check("lk_pre_c_gnt", 32'(c_gnt), 32'd1);
        tick();
        c_addr = 6'd12;
        d_req = 1'b1; d_we = 1'b0; d_addr = 6'd11; d_lock = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lk_d_gnt", 32'(d_gnt), 32'd1);
            check("lk_c_gnt", 32'(c_gnt), 32'd0);
            tick();
        end
        d_lock = 1'b0;
        @(negedge clk);
        check("lk_release_c_gnt", 32'(c_gnt), 32'd1);
        check("lk_conflicts", 32'(conflicts), 32'd4);
        tick();
        c_req = 1'b0; d_req = 1'b0;

        // Reset pulse while a C read is being granted.
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 6'd20;
        @(negedge clk);
        check("mr_c_gnt", 32'(c_gnt), 32'd1);
        #2;
        rst = 1'b0; c_req = 1'b0;
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("mr_c_rvalid", 32'(c_rvalid), 32'd0);
        tick();
        c_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        @(negedge clk);
        check("mr_c_first", 32'(c_gnt), 32'd1);
        check("mr_conflicts", 32'(conflicts), 32'd0);
        check("mr_c_rvalid2", 32'(c_rvalid), 32'd0);
        tick();

        // Saturation of the conflict counter.
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 6'd30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 6'd31;
        repeat (300) tick();
        @(negedge clk);
        check("sat_conflicts", 32'(conflicts), 32'd255);
        tick();
        c_req = 1'b0; d_req = 1'b0;
        do_reset();

        // Random traffic over a small address window; occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if (!(c_req && !seen_c_gnt && ($urandom_range(7) != 0))) begin
                c_req = 1'($urandom_range(1));
                c_we = 1'($urandom_range(1));
                c_addr = AW'($urandom_range(7));
                c_wdata = DW'($urandom_range(1023));
            end
            if (!(d_req && !seen_d_gnt && ($urandom_range(7) != 0))) begin
                d_req = 1'($urandom_range(1));
                d_we = 1'($urandom_range(1));
                d_addr = AW'($urandom_range(7));
                d_wdata = DW'($urandom_range(1023));
            end
            d_lock = ($urandom_range(3) == 0);
            rst = ($urandom_range(199) != 0);
            tick();
        end
        rst = 1'b1; c_req = 1'b0; d_req = 1'b0;
        tick();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fb_mem_arbiter.md
# fb_mem_arbiter

Two-port arbiter that shares the single-port 64x10 block RAM between the fb_cpu memory interface (port C) and a debug/loader port (port D) used to load programs and inspect results. It issues at most one RAM access per cycle, picks a winner by round-robin with an optional debug lock, and routes the one-cycle-late read data back to the port that issued the read. It sits between the CPU/debug masters and blram and owns the RAM's we/addr/data-in pins.

## Interface
- ADDRESS_WIDTH, 6, RAM address width (64 words)
- DATA_WIDTH, 10, RAM word width

- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- c_req / d_req  input  1  access request, port C / D
- c_we / d_we  input  1  1 = write, 0 = read
- c_addr / d_addr  input  ADDRESS_WIDTH  word address
- c_wdata / d_wdata  input  DATA_WIDTH  write data
- d_lock  input  1  while high and D holds the grant, C is never granted
- c_gnt / d_gnt  output  1  request accepted this cycle (combinational)
- c_rvalid / d_rvalid  output  1  read data valid (registered)
- c_rdata / d_rdata  output  DATA_WIDTH  read data; 0 when the matching rvalid is low
- ram_we  output  1  RAM write enable
- ram_addr  output  ADDRESS_WIDTH  RAM address
- ram_wdata  output  DATA_WIDTH  RAM write data
- ram_rdata  input  DATA_WIDTH  RAM registered read output
- conflicts  output  8  saturating count of cycles with a denied request

## Operation
- One access per cycle. Winner W is chosen combinationally from c_req, d_req, last, and lock state.
  - Only one port requests: that port wins, unless C requests while lock_held = 1 (then no grant).
  - Both request: lock_held = 1 -> D; otherwise the port not equal to last wins (round-robin).
  - No request: no grant, ram_we = 0, ram_addr = 0, ram_wdata = 0.
- Winner's addr/we/wdata drive ram_addr/ram_we/ram_wdata in the same cycle; its gnt is high.
- State registers:
  - last: port of the most recent grant (0 = C, 1 = D); updates only on a grant.
  - lock_held: set when D is granted while d_lock = 1; cleared on the first cycle d_lock = 0.
  - pend_c / pend_d: set for one cycle after a granted read of the respective port.
  - conflicts: +1 in every cycle where a port requested and was not granted; saturates at 255.
- Read return: c_rvalid = pend_c, c_rdata = pend_c ? ram_rdata : 0; same for D. pend_c and pend_d are never both 1.
- Writes produce no response beyond gnt. Back-to-back grants to the same or alternate ports are legal every cycle.
- A requester must hold req/we/addr/wdata stable until it sees gnt. Dropping req without a grant is legal and leaves no state.

## Timing
- Reset (rst low, asynchronous): last = 1 (C wins the first contest), lock_held = 0, pend_c = pend_d = 0, conflicts = 0.
  - Outputs during reset: c_gnt = d_gnt = 0 and ram_we = 0, regardless of requests.
  - All other outputs are 0 during reset.
- Reset asserted mid-read clears pending rvalid. No rvalid appears after rst deasserts for a read granted before reset.
- Grant latency: 0 cycles (gnt is in the same cycle as req, when winning).
- Read latency: rvalid is exactly 1 cycle after the granting edge, matching blram's registered output.
- Write takes effect at the granting edge. A read of the same address granted in the next cycle returns the new data.
- Simultaneous C and D requests to the same address: only the winner accesses; the loser waits.
- Lock release: if D keeps requesting after d_lock falls, the next contest follows round-robin with last = 1, so C wins.
- conflicts counts a both-request cycle as 1. It counts a C-only request blocked by lock as 1.

## Test plan
- Reset behaviour: hold rst low with c_req = d_req = 1 -> c_gnt = d_gnt = 0, ram_we = 0, conflicts = 0; release rst -> C granted first cycle.
- Single port read after write: D writes 0x155 to addr 50, then reads 50 -> d_gnt each cycle; d_rvalid high one cycle after the read, d_rdata = 0x155; c_rvalid stays 0.
- Contention: both ports request continuously for 6 cycles (C reads 51, D reads 52) -> grants alternate C, D, C, D, C, D; conflicts = 6; each rvalid returns to its own port with correct data.
- Lock: D requests with d_lock = 1 for 4 cycles while C requests -> D granted 4 times, C denied; d_lock drops -> C granted next cycle; conflicts = 4.
- Reset mid-read: C read granted, rst pulses low before the next edge -> c_rvalid never asserts; state returns to reset values.
- Saturation: sustain contention for 300 cycles -> conflicts holds at 255, no wrap.
